// File: rtl/dispense_cmd_parser.sv
// Dispense command parser: pops bytes from the command FIFO, assembles
// SOF/slot/qty/checksum frames and presents validated commands to the sequencer.
module dispense_cmd_parser #(
  parameter int         NUM_SLOTS      = 8,
  parameter int         MAX_QTY        = 4,
  parameter int         TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  localparam int        SLOT_W         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int        TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_dout,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [SLOT_W-1:0] cmd_slot,
  output logic [7:0]        cmd_qty,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [15:0]       good_frames,
  output logic              busy
);

  typedef enum logic [2:0] {HUNT, GET_SLOT, GET_QTY, GET_CSUM, PRESENT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic              pending_reg, pending_next;
  logic [7:0]        slot_reg, slot_next;
  logic [7:0]        qty_reg, qty_next;
  logic [SLOT_W-1:0] cmd_slot_reg, cmd_slot_next;
  logic [7:0]        cmd_qty_reg, cmd_qty_next;
  logic              err_pulse_reg, err_pulse_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic [15:0]       good_reg, good_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              frame_bad;
  logic [1:0]        frame_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      pending_reg   <= 1'b0;
      slot_reg      <= '0;
      qty_reg       <= '0;
      cmd_slot_reg  <= '0;
      cmd_qty_reg   <= '0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= '0;
      good_reg      <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      slot_reg      <= slot_next;
      qty_reg       <= qty_next;
      cmd_slot_reg  <= cmd_slot_next;
      cmd_qty_reg   <= cmd_qty_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
      good_reg      <= good_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  // Frame validation on the incoming checksum byte; checksum wins over range errors.
  always_comb begin
    frame_bad  = 1'b1;
    frame_code = 2'd0;
    if (fifo_dout != (slot_reg ^ qty_reg)) begin
      frame_code = 2'd1;
    end else if (int'(slot_reg) >= NUM_SLOTS) begin
      frame_code = 2'd2;
    end else if (qty_reg == 8'd0 || int'(qty_reg) > MAX_QTY) begin
      frame_code = 2'd3;
    end else begin
      frame_bad = 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    qty_next       = qty_reg;
    cmd_slot_next  = cmd_slot_reg;
    cmd_qty_next   = cmd_qty_reg;
    err_pulse_next = 1'b0;
    err_code_next  = err_code_reg;
    good_next      = good_reg;
    to_cnt_next    = to_cnt_reg;
    fifo_rd_en     = (state_reg != PRESENT) && !fifo_empty && !pending_reg;
    pending_next   = fifo_rd_en;

    case (state_reg)
      HUNT: begin
        if (pending_reg && fifo_dout == SOF_BYTE) begin
          state_next  = GET_SLOT;
          to_cnt_next = '0;
        end
      end
      GET_SLOT, GET_QTY, GET_CSUM: begin
        // A byte landing in the timeout cycle keeps the frame alive.
        if (pending_reg) begin
          to_cnt_next = '0;
          if (state_reg == GET_SLOT) begin
            slot_next  = fifo_dout;
            state_next = GET_QTY;
          end else if (state_reg == GET_QTY) begin
            qty_next   = fifo_dout;
            state_next = GET_CSUM;
          end else if (frame_bad) begin
            err_pulse_next = 1'b1;
            err_code_next  = frame_code;
            state_next     = HUNT;
          end else begin
            cmd_slot_next = slot_reg[SLOT_W-1:0];
            cmd_qty_next  = qty_reg;
            state_next    = PRESENT;
          end
        end else if (to_cnt_reg == TO_LAST) begin
          to_cnt_next    = '0;
          err_pulse_next = 1'b1;
          err_code_next  = 2'd0;
          state_next     = HUNT;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      PRESENT: begin
        if (cmd_ready) begin
          state_next = HUNT;
          if (good_reg != 16'hFFFF) begin
            good_next = good_reg + 16'd1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign cmd_valid   = (state_reg == PRESENT);
  assign cmd_slot    = cmd_slot_reg;
  assign cmd_qty     = cmd_qty_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;
  assign good_frames = good_reg;
  assign busy        = (state_reg != HUNT);

endmodule

// File: tb/tb_dispense_cmd_parser.sv
// Scoreboard bench for dispense_cmd_parser: a frame-level byte-stream model
// queues expected commands/errors, a monitor compares them as the DUT emits them.
module tb_dispense_cmd_parser;
  localparam int         NUM_SLOTS      = 8;
  localparam int         MAX_QTY        = 4;
  localparam int         TIMEOUT_CYCLES = 100;
  localparam logic [7:0] SOF            = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_slot;
  logic [7:0]  cmd_qty;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] good_frames;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int ready_mode = 0;  // 0: always ready, 1: held low, 2: random

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [7:0]  slot;
    logic [7:0]  qty;
    logic [15:0] good_before;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] m_buf[$];
  int         m_good = 0;

  dispense_cmd_parser #(
    .NUM_SLOTS(NUM_SLOTS), .MAX_QTY(MAX_QTY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SOF_BYTE(SOF)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slot(cmd_slot), .cmd_qty(cmd_qty), .err_pulse(err_pulse),
    .err_code(err_code), .good_frames(good_frames), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Byte FIFO: data appears the cycle after a pop, empty flag is registered.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) cmd_ready = 1'b1;
      else if (ready_mode == 1) cmd_ready = 1'b0;
      else cmd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic fail_unexpected(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d want none", name, act);
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Stream-level reference: hunt for SOF, collect 4 bytes, judge the frame.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] s, q, c;
    exp_t e;
    if (m_buf.size() != 0 || b == SOF) begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        s = m_buf[1];
        q = m_buf[2];
        c = m_buf[3];
        m_buf.delete();
        if (c != (s ^ q)) expect_err(2'd1);
        else if (int'(s) >= NUM_SLOTS) expect_err(2'd2);
        else if (q == 8'd0 || int'(q) > MAX_QTY) expect_err(2'd3);
        else begin
          e = '0;
          e.slot = s;
          e.qty = q;
          e.good_before = 16'(m_good);
          exp_q.push_back(e);
          m_good++;
        end
      end
    end
  endtask

  task automatic model_timeout();
    if (m_buf.size() != 0) begin
      expect_err(2'd0);
      m_buf.delete();
    end
  endtask

  task automatic put(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    put(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_wait", fifo_q.size(), 0);
  endtask

  task automatic gap(input int len);
    drain();
    if (len > TIMEOUT_CYCLES + 10) model_timeout();
    repeat (len) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_wait_pending", exp_q.size(), 0);
  endtask

  task automatic wait_pops(input int n, output int at);
    int seen, k;
    seen = 0;
    k = 0;
    at = 0;
    while (seen < n && k < 500) begin
      @(negedge clk);
      k++;
      if (fifo_rd_en) begin
        seen++;
        at = cycle;
      end
    end
    if (seen < n) chk("pop_wait", seen, n);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_fifo_rd_en"}, int'(fifo_rd_en), 0);
    chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
    chk({tag, "_cmd_slot"}, int'(cmd_slot), 0);
    chk({tag, "_cmd_qty"}, int'(cmd_qty), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_good_frames"}, int'(good_frames), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin : monitor
    exp_t       e;
    logic       prev_rd, prev_err;
    logic [1:0] last_code;
    prev_rd = 1'b0;
    prev_err = 1'b0;
    last_code = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0;
        prev_err = 1'b0;
        last_code = 2'd0;
      end else begin
        if (fifo_rd_en) chk("pop_spacing", int'(prev_rd), 0);
        if (cmd_valid) chk("present_rd_en_busy", int'({fifo_rd_en, busy}), 1);
        if (err_pulse) begin
          chk("err_single_cycle", int'(prev_err), 0);
          if (exp_q.size() == 0) fail_unexpected("unexpected_err", int'(err_code));
          else begin
            e = exp_q.pop_front();
            $display("[%0d] err code=%0d", cycle, err_code);
            chk("event_kind_err", 1, int'(e.is_err));
            chk("err_code", int'(err_code), int'(e.code));
            last_code = e.code;
          end
        end
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) fail_unexpected("unexpected_cmd", int'(cmd_slot));
          else begin
            e = exp_q.pop_front();
            $display("[%0d] cmd slot=%0d qty=%0d good=%0d", cycle, cmd_slot, cmd_qty, good_frames);
            chk("event_kind_cmd", 0, int'(e.is_err));
            chk("cmd_slot", int'(cmd_slot), int'(e.slot));
            chk("cmd_qty", int'(cmd_qty), int'(e.qty));
            chk("good_frames", int'(good_frames), int'(e.good_before));
            chk("err_code_held", int'(err_code), int'(last_code));
          end
        end
        prev_rd = fifo_rd_en;
        prev_err = err_pulse;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    int t_pop, n, viol, r;
    logic [7:0] s, q;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_values("reset");

    // Single good frame with ready held high.
    ready_mode = 0;
    put(8'hA5); put(8'h03); put(8'h02); put(8'h01);
    wait_pops(4, t_pop);
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    chk("csum_to_valid_latency", cycle - t_pop, 2);
    @(negedge clk);
    chk("valid_one_cycle", int'(cmd_valid), 0);
    wait_idle();
    chk("good_after_first", int'(good_frames), m_good);

    // Back-pressure: command held while ready is low, then a second frame.
    ready_mode = 1;
    put(8'hA5); put(8'h03); put(8'h02); put(8'h01);
    put(8'hA5); put(8'h00); put(8'h01); put(8'h01);
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (!cmd_valid || cmd_slot != 3'd3 || cmd_qty != 8'd2 || fifo_rd_en) viol++;
    end
    chk("hold_while_not_ready", viol, 0);
    ready_mode = 0;
    wait_idle();

    // Leading junk, then a checksum error.
    put(8'h11); put(8'h22); put(8'hA5); put(8'h01); put(8'h01); put(8'h07);
    wait_idle();

    // Stall after the slot byte: timeout 100 cycles after it is processed.
    put(8'hA5); put(8'h02);
    model_timeout();
    wait_pops(2, t_pop);
    n = 0;
    while (!err_pulse && n < 300) begin @(negedge clk); n++; end
    chk("timeout_latency", cycle - t_pop, TIMEOUT_CYCLES + 2);
    put(8'hA5); put(8'h02); put(8'h03); put(8'h01);
    wait_idle();

    // Range errors: slot, qty too large, qty zero.
    put(8'hA5); put(8'h09); put(8'h01); put(8'h08);
    put(8'hA5); put(8'h01); put(8'h05); put(8'h04);
    put(8'hA5); put(8'h01); put(8'h00); put(8'h01);
    wait_idle();
    chk("err_code_before_reset", int'(err_code), 3);

    // Reset in the middle of a frame.
    put(8'hA5); put(8'h02);
    wait_pops(2, t_pop);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    m_buf.delete();
    m_good = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_values("midframe_reset");
    put(8'hA5); put(8'h04); put(8'h01); put(8'h05);
    wait_idle();
    chk("good_after_reset", int'(good_frames), m_good);

    // Randomized stream: good/bad frames, junk, truncated frames, stalls.
    ready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        s = 8'($urandom_range(0, NUM_SLOTS - 1));
        q = 8'($urandom_range(1, MAX_QTY));
        send(SOF); send(s); send(q); send(s ^ q);
      end else if (r <= 5) begin
        s = 8'($urandom_range(0, 15));
        q = 8'($urandom_range(0, 6));
        send(SOF); send(s); send(q);
        if ($urandom_range(0, 1) == 0) send(s ^ q);
        else send(8'($urandom_range(0, 255)));
      end else if (r == 6) begin
        repeat (1 + $urandom_range(0, 2)) send(8'($urandom_range(0, 255)));
      end else if (r == 7) begin
        send(SOF);
        repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 255)));
      end else if (r == 8) begin
        gap(1 + int'($urandom_range(0, 19)));
      end else begin
        gap(TIMEOUT_CYCLES + 50);
      end
    end
    gap(TIMEOUT_CYCLES + 50);
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("good_final", int'(good_frames), m_good);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
